aes_round_sequencer: RTL and testbench

// Top-level control FSM for the AES-128 encrypt datapath. Sequences the step blocks
//   (addRoundKey, subBytes, shiftRows, mixColumns) through the initial key add and
//   NUM_ROUNDS rounds, using an enable/done handshake with each block.

---
 rtl/aes_round_sequencer.sv | 172 +++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Control FSM for the AES-128 encrypt datapath. It runs the step blocks in
//   order: the initial addRoundKey, then NUM_ROUNDS rounds of
//   subBytes/shiftRows/mixColumns/addRoundKey. The last round skips mixColumns.
//   Each step gets a one-cycle *_en pulse, and the step completes on a rising
//   edge of its *_done level. All outputs are registered.
// Ports
//   clk, rst                   clock, async active-high reset
//   start                      begin an encryption (sampled in IDLE only)
//   busy, done, error          host status (done is a 1-cycle pulse)
//   round, state_sel           key-schedule round index, state-register mux select
//   ark/sb/sr/mc_en            step enable pulses
//   ark/sb/sr/mc_done          step done levels
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int TIMEOUT    = 255,
  parameter int TW         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] round,
  output logic       state_sel,
  output logic       ark_en,
  output logic       sb_en,
  output logic       sr_en,
  output logic       mc_en,
  input  logic       ark_done,
  input  logic       sb_done,
  input  logic       sr_done,
  input  logic       mc_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARK0, S_SB, S_SR, S_MC, S_ARK, S_FINISH, S_ERR
  } state_t;

  // Bit index of each step block in the en/done vectors.
  localparam int B_ARK = 0;
  localparam int B_SB  = 1;
  localparam int B_SR  = 2;
  localparam int B_MC  = 3;

  function automatic logic [1:0] blk_of(state_t s);
    case (s)
      S_SB:    blk_of = 2'(B_SB);
      S_SR:    blk_of = 2'(B_SR);
      S_MC:    blk_of = 2'(B_MC);
      default: blk_of = 2'(B_ARK);
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          first_q, first_d;       // first cycle in a step state
  logic [3:0]    done_q, done_d;         // previous-cycle done levels
  logic [3:0]    en_q, en_d;
  logic          busy_q, busy_d;
  logic          fin_q, fin_d;
  logic          err_q, err_d;
  logic          sel_q, sel_d;

  logic [3:0]    done_in, done_edge;
  logic          step_edge, last_round;
  state_t        nxt;

  assign done_in    = {mc_done, sr_done, sb_done, ark_done};
  assign done_edge  = done_in & ~done_q;
  // An edge in the entry cycle is ignored; the block cannot have finished yet.
  assign step_edge  = done_edge[blk_of(state_q)] && !first_q;
  assign last_round = (round_q == 4'(NUM_ROUNDS));

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    tmo_d   = tmo_q;
    first_d = 1'b0;
    done_d  = done_in;
    en_d    = '0;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    err_d   = err_q;
    sel_d   = sel_q;
    nxt     = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_ARK0;
          round_d      = '0;
          sel_d        = 1'b0;
          busy_d       = 1'b1;
          err_d        = 1'b0;
          tmo_d        = '0;
          first_d      = 1'b1;
          en_d[B_ARK]  = 1'b1;
        end
      end
      S_FINISH, S_ERR: state_d = S_IDLE;
      default: begin
        // A done edge takes priority over a timeout in the same cycle.
        if (step_edge) begin
          case (state_q)
            S_ARK0: begin nxt = S_SB; round_d = 4'd1; sel_d = 1'b1; end
            S_SB:   nxt = S_SR;
            S_SR:   nxt = last_round ? S_ARK : S_MC;
            S_MC:   nxt = S_ARK;
            default: begin
              if (last_round) nxt = S_FINISH;
              else begin nxt = S_SB; round_d = round_q + 4'd1; end
            end
          endcase
          state_d = nxt;
          if (nxt == S_FINISH) begin
            busy_d = 1'b0;
            fin_d  = 1'b1;
          end else begin
            tmo_d             = '0;
            first_d           = 1'b1;
            en_d[blk_of(nxt)] = 1'b1;
          end
        end else if (tmo_q == TW'(TIMEOUT)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      tmo_q   <= '0;
      first_q <= 1'b0;
      done_q  <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      tmo_q   <= tmo_d;
      first_q <= first_d;
      done_q  <= done_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end

  assign busy      = busy_q;
  assign done      = fin_q;
  assign error     = err_q;
  assign round     = round_q;
  assign state_sel = sel_q;
  assign ark_en    = en_q[B_ARK];
  assign sb_en     = en_q[B_SB];
  assign sr_en     = en_q[B_SR];
  assign mc_en     = en_q[B_MC];

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;
  localparam int NR  = 10;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done, error, state_sel, ark_en, sb_en, sr_en, mc_en;
  logic [3:0] round;
  logic [3:0] done_in = '0;
  logic [3:0] dut_en;

  aes_round_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT(TMO), .TW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .round(round), .state_sel(state_sel), .ark_en(ark_en), .sb_en(sb_en),
    .sr_en(sr_en), .mc_en(mc_en), .ark_done(done_in[0]), .sb_done(done_in[1]),
    .sr_done(done_in[2]), .mc_done(done_in[3])
  );

  assign dut_en = {mc_en, sr_en, sb_en, ark_en};
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // ---------------- step-block stubs ----------------
  int lat_min = 1, lat_max = 1, hold_min = 1, hold_max = 1;
  bit noise_on = 1'b0;
  logic [3:0] ovr_en = '0, ovr_val = '0;
  int scnt[4];
  int shold[4];

  initial begin
    logic [3:0] stub, noise;
    for (int b = 0; b < 4; b++) begin scnt[b] = 0; shold[b] = 0; end
    forever begin
      @(posedge clk);
      #2;
      noise = '0;
      for (int b = 0; b < 4; b++) begin
        if (dut_en[b]) scnt[b] = int'($urandom_range(lat_max, lat_min));
        else if (scnt[b] > 0) begin
          scnt[b]--;
          if (scnt[b] == 0) shold[b] = int'($urandom_range(hold_max, hold_min));
        end
        stub[b] = (shold[b] > 0);
        if (shold[b] > 0) shold[b]--;
      end
      if (noise_on && ($urandom_range(15, 0) == 0)) noise[$urandom_range(3, 0)] = 1'b1;
      for (int b = 0; b < 4; b++)
        done_in[b] = ovr_en[b] ? ovr_val[b] : (stub[b] | noise[b]);
    end
  end

  // ---------------- behavioural model ----------------
  // The encryption is a flat list of steps (block, round); the model walks it.
  int blk_tab[64];
  int rnd_tab[64];
  int nsteps;
  logic       exp_busy = 0, exp_done = 0, exp_error = 0, exp_sel = 0;
  logic [3:0] exp_round = '0, exp_en = '0;

  initial begin
    int phase, k, age, tc;
    logic [3:0] prev, edges;
    nsteps = 0;
    blk_tab[0] = 0; rnd_tab[0] = 0; nsteps = 1;
    for (int r = 1; r <= NR; r++) begin
      blk_tab[nsteps] = 1; rnd_tab[nsteps] = r; nsteps++;
      blk_tab[nsteps] = 2; rnd_tab[nsteps] = r; nsteps++;
      if (r < NR) begin blk_tab[nsteps] = 3; rnd_tab[nsteps] = r; nsteps++; end
      blk_tab[nsteps] = 0; rnd_tab[nsteps] = r; nsteps++;
    end
    phase = 0; k = 0; age = 0; tc = 0; prev = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        phase = 0; k = 0; age = 0; tc = 0; prev = '0;
        exp_busy = 0; exp_done = 0; exp_error = 0; exp_sel = 0;
        exp_round = '0; exp_en = '0;
      end else begin
        edges = done_in & ~prev;
        prev  = done_in;
        exp_en = '0;
        exp_done = 1'b0;
        case (phase)
          0: if (start) begin
            phase = 1; k = 0; age = 0; tc = 0;
            exp_en[blk_tab[0]] = 1'b1;
            exp_busy = 1; exp_error = 0; exp_round = '0; exp_sel = 0;
          end
          1: begin
            if (age > 0 && edges[blk_tab[k]]) begin
              k++;
              if (k == nsteps) begin
                phase = 2; exp_done = 1; exp_busy = 0;
              end else begin
                age = 0; tc = 0;
                exp_en[blk_tab[k]] = 1'b1;
                exp_round = 4'(rnd_tab[k]);
                exp_sel = 1;
              end
            end else if (tc == TMO) begin
              phase = 3; exp_error = 1; exp_busy = 0;
            end else begin
              tc++; age++;
            end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare + enable monitor ----------------
  typedef struct packed { logic [1:0] b; logic [3:0] r; } ev_t;
  ev_t ev_q[$];
  int  en_cnt[4];

  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if ({busy, done, error, round, state_sel, dut_en} !==
          {exp_busy, exp_done, exp_error, exp_round, exp_sel, exp_en}) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t got busy=%b done=%b err=%b rnd=%0d sel=%b en=%b, expected busy=%b done=%b err=%b rnd=%0d sel=%b en=%b",
                 $time, busy, done, error, round, state_sel, dut_en,
                 exp_busy, exp_done, exp_error, exp_round, exp_sel, exp_en);
      end
      if (!rst)
        for (int b = 0; b < 4; b++)
          if (dut_en[b]) begin
            en_cnt[b]++;
            ev_q.push_back('{b: 2'(b), r: round});
          end
    end
  end

  task automatic clear_mon();
    for (int b = 0; b < 4; b++) en_cnt[b] = 0;
    ev_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start (or holds it) and returns the negedge index (1 = first cycle
  // after the sampling edge) at which done is seen; -1 if never.
  task automatic run_enc(input bit hold, output int cyc);
    tick();
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (done) begin cyc = n; break; end
    end
  endtask

  task automatic wait_done(input int lim, output int cyc);
    cyc = -1;
    for (int n = 1; n <= lim; n++) begin
      @(negedge clk);
      if (done) begin cyc = n; break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n0, k, nxt, mc9, mc10, sum0;
    int ark_r[$];
    for (int b = 0; b < 4; b++) en_cnt[b] = 0;
    #1 rst = 1'b1;
    #2;
    check("reset_outputs", int'({busy, done, error, round, state_sel, dut_en}), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) tick();

    // 1: nominal run, one-cycle stubs
    clear_mon();
    run_enc(1'b0, cyc);
    check("t1_done_cycle", cyc, 81);
    check("t1_ark_cnt", en_cnt[0], 11);
    check("t1_sb_cnt", en_cnt[1], 10);
    check("t1_sr_cnt", en_cnt[2], 10);
    check("t1_mc_cnt", en_cnt[3], 9);
    check("t1_round_at_done", int'(round), 10);
    ark_r.delete();
    foreach (ev_q[i]) if (ev_q[i].b == 2'd0) ark_r.push_back(int'(ev_q[i].r));
    check("t1_ark_rounds_len", ark_r.size(), 11);
    foreach (ark_r[i]) check("t1_ark_round_seq", ark_r[i], i);

    // 2: last round skips mixColumns
    nxt = 7; mc9 = 0; mc10 = 0;
    for (int i = 0; i + 1 < ev_q.size(); i++)
      if (ev_q[i].b == 2'd2 && ev_q[i].r == 4'd10) nxt = int'(ev_q[i+1].b);
    foreach (ev_q[i]) begin
      if (ev_q[i].b == 2'd3 && ev_q[i].r == 4'd9)  mc9++;
      if (ev_q[i].b == 2'd3 && ev_q[i].r == 4'd10) mc10++;
    end
    check("t2_after_sr10_is_ark", nxt, 0);
    check("t2_mc_round9", mc9, 1);
    check("t2_mc_round10", mc10, 0);

    // 3: subBytes never finishes -> timeout
    tick();
    ovr_en[1] = 1'b1; ovr_val[1] = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n0 = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sb_en) begin n0 = n; break; end
    end
    check("t3_sb_en_seen", int'(n0 >= 0), 1);
    k = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (error) begin k = n; break; end
    end
    check("t3_error_delay", k, TMO + 1);
    check("t3_busy_low", int'(busy), 0);
    clear_mon();
    repeat (5) @(negedge clk);
    sum0 = en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3];
    check("t3_no_en_after_err", sum0, 0);
    check("t3_error_held", int'(error), 1);
    tick();
    ovr_en[1] = 1'b0;
    run_enc(1'b0, cyc);
    check("t3_recover_cycle", cyc, 81);
    check("t3_error_cleared", int'(error), 0);

    // 4: shiftRows done already high on entry
    tick();
    ovr_en[2] = 1'b1; ovr_val[2] = 1'b1;
    tick();
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sr_en) break;
    end
    check("t4_sr_entered", en_cnt[2], 1);
    repeat (10) @(negedge clk);
    check("t4_no_advance", en_cnt[3], 0);
    check("t4_busy", int'(busy), 1);
    tick(); ovr_val[2] = 1'b0;
    tick(); ovr_val[2] = 1'b1;
    tick(); ovr_en[2] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (en_cnt[3] > 0) break;
    end
    check("t4_advanced_to_mc", en_cnt[3], 1);
    wait_done(200, cyc);
    check("t4_completed", int'(cyc > 0), 1);

    // 5: reset in MC at round 5
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (mc_en && round == 4'd5) begin k = 1; break; end
    end
    check("t5_reached_mc5", k, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_reset_outputs", int'({busy, done, error, round, state_sel, dut_en}), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    run_enc(1'b0, cyc);
    check("t5_rerun_cycle", cyc, 81);

    // 6: start held high
    clear_mon();
    run_enc(1'b1, cyc);
    check("t6_first_run", cyc, 81);
    check("t6_single_enc", en_cnt[0], 11);
    check("t6_busy_finish", int'(busy), 0);
    @(negedge clk);
    check("t6_idle_no_en", int'(dut_en), 0);
    @(negedge clk);
    check("t6_restart_ark", int'(ark_en), 1);
    check("t6_restart_busy", int'(busy), 1);
    #1 start = 1'b0;
    wait_done(200, cyc);
    check("t6_second_done", int'(cyc > 0), 1);

    // random traffic: variable latencies, stray done pulses, stray starts, resets
    lat_min = 1; lat_max = 4; hold_min = 1; hold_max = 3; noise_on = 1'b1;
    for (int it = 0; it < 25; it++) begin
      tick();
      start = 1'b1;
      repeat ($urandom_range(3, 1)) tick();
      start = 1'b0;
      k = ($urandom_range(5, 0) == 0) ? int'($urandom_range(150, 5)) : -1;
      for (int c = 0; c < 220; c++) begin
        tick();
        start = ($urandom_range(7, 0) == 0);
        if (c == k) begin
          #1 rst = 1'b1;
          @(posedge clk);
          #2 rst = 1'b0;
        end
      end
      start = 1'b0;
    end
    noise_on = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
